// File: rtl/sr_piso_4bit_ctrl_if.sv
// Parallel-word input and serial-bit output bundle of the PISO controller.
// Handshake: a word moves on a rising edge where din_valid && din_ready; din_valid may rise without waiting for din_ready, and the producer holds din stable until that edge.
interface sr_piso_4bit_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, busy
  );
endinterface

// File: rtl/sr_piso_4bit_ctrl.sv
// Serializes one WIDTH-bit word per transfer onto a registered serial line.
// Optional even-parity trailer bit is enabled by defining SR_PISO_PARITY_EN.
module sr_piso_4bit_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  sr_piso_4bit_ctrl_if.slave      bus,
  output logic [1:0]              state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SR_PISO_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             sout_r;
  logic             sout_valid_r;
  logic             busy_r;

  logic [WIDTH-1:0] sh_lsb;
  logic [WIDTH-1:0] sh_msb;
  logic             first_bit;
  logic             next_bit;

  // cnt is the index (in emission order) of the bit to drive at the next edge.
  always_comb begin
    sh_lsb    = shreg >> cnt;
    sh_msb    = shreg << cnt;
    first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
    next_bit  = MSB_FIRST ? sh_msb[WIDTH-1] : sh_lsb[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            shreg        <= bus.din;
            sout_r       <= first_bit;
            sout_valid_r <= 1'b1;
            cnt          <= CNT_ONE;
            busy_r       <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt < CNT_MAX) begin
            sout_r <= next_bit;
            cnt    <= cnt + CNT_ONE;
          end else begin
            cnt <= '0;
`ifdef SR_PISO_PARITY_EN
            sout_r       <= ^shreg;
            sout_valid_r <= 1'b1;
            state        <= PARITY;
`else
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            state        <= IDLE;
`endif
          end
        end
`ifdef SR_PISO_PARITY_EN
        PARITY: begin
          sout_r       <= 1'b0;
          sout_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state        <= IDLE;
        end
`endif
        default: begin
          cnt          <= '0;
          sout_r       <= 1'b0;
          sout_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.din_ready  = (state == IDLE);
  assign bus.sout       = sout_r;
  assign bus.sout_valid = sout_valid_r;
  assign bus.busy       = busy_r;
  assign state_dbg      = state;
endmodule

// File: tb/tb_sr_piso_4bit_ctrl.sv
// Directed bench for sr_piso_4bit_ctrl: one LSB-first and one MSB-first instance driven in lockstep.
// Expectations follow the parity trailer when SR_PISO_PARITY_EN is defined.
module tb_sr_piso_4bit_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] state_l;
  logic [1:0] state_m;

  int n_tests = 0;
  int n_fail  = 0;

  sr_piso_4bit_ctrl_if #(.WIDTH(4)) bus_l ();
  sr_piso_4bit_ctrl_if #(.WIDTH(4)) bus_m ();

  sr_piso_4bit_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_l),
    .state_dbg (state_l)
  );

  sr_piso_4bit_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_m),
    .state_dbg (state_m)
  );

  // seq_x[i] is the i-th bit on sout for that bit order
  typedef struct {
    logic [3:0] din;
    logic [3:0] seq_l;
    logic [3:0] seq_m;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic v);
    bus_l.din       = d;
    bus_m.din       = d;
    bus_l.din_valid = v;
    bus_m.din_valid = v;
  endtask

  task automatic check_bit(input string tag, input logic bl, input logic bm);
    check({tag, " sout_l"}, 16'(bus_l.sout), 16'(bl));
    check({tag, " sout_m"}, 16'(bus_m.sout), 16'(bm));
    check({tag, " valid"}, {14'd0, bus_l.sout_valid, bus_m.sout_valid}, 16'h3);
    check({tag, " busy"}, {14'd0, bus_l.busy, bus_m.busy}, 16'h3);
    check({tag, " ready"}, {14'd0, bus_l.din_ready, bus_m.din_ready}, 16'h0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle sout"}, {14'd0, bus_l.sout, bus_m.sout}, 16'h0);
    check({tag, " idle valid"}, {14'd0, bus_l.sout_valid, bus_m.sout_valid}, 16'h0);
    check({tag, " idle busy"}, {14'd0, bus_l.busy, bus_m.busy}, 16'h0);
    check({tag, " idle ready"}, {14'd0, bus_l.din_ready, bus_m.din_ready}, 16'h3);
    check({tag, " idle state"}, {12'd0, state_l, state_m}, 16'h0);
  endtask

  // One-cycle valid pulse; din is scrambled while shifting to prove the capture holds.
  task automatic run_frame(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.din, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drive(~v.din, 1'b0);
      check_bit($sformatf("%s bit%0d", tag, i), v.seq_l[i], v.seq_m[i]);
    end
`ifdef SR_PISO_PARITY_EN
    @(negedge clk);
    check_bit({tag, " parity"}, v.par, v.par);
`endif
    @(negedge clk);
    check_idle(tag);
  endtask

  initial begin
    vecs[0] = '{din: 4'b1010, seq_l: 4'b1010, seq_m: 4'b0101, par: 1'b0};
    vecs[1] = '{din: 4'b1100, seq_l: 4'b1100, seq_m: 4'b0011, par: 1'b0};
    vecs[2] = '{din: 4'b1011, seq_l: 4'b1011, seq_m: 4'b1101, par: 1'b1};
    vecs[3] = '{din: 4'b0011, seq_l: 4'b0011, seq_m: 4'b1100, par: 1'b0};
    vecs[4] = '{din: 4'b0001, seq_l: 4'b0001, seq_m: 4'b1000, par: 1'b1};
    vecs[5] = '{din: 4'b1111, seq_l: 4'b1111, seq_m: 4'b1111, par: 1'b0};
    vecs[6] = '{din: 4'b0110, seq_l: 4'b0110, seq_m: 4'b0110, par: 1'b0};

    // Reset with a word offered: it must be dropped.
    rst = 1'b0;
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst%0d sout", i), {14'd0, bus_l.sout, bus_m.sout}, 16'h0);
      check($sformatf("rst%0d valid", i), {14'd0, bus_l.sout_valid, bus_m.sout_valid}, 16'h0);
      check($sformatf("rst%0d busy", i), {14'd0, bus_l.busy, bus_m.busy}, 16'h0);
    end
    rst = 1'b1;
    drive(4'b1111, 1'b0);
    check("release ready", {14'd0, bus_l.din_ready, bus_m.din_ready}, 16'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("post_rst%0d", i));
    end

    foreach (vecs[k]) run_frame(vecs[k], $sformatf("vec%0d", k));

    // Back-to-back: valid held high, 5 then 3, exactly one idle cycle between.
    @(negedge clk);
    drive(4'h5, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] s_l;
      logic [3:0] s_m;
      s_l = 4'b0101;
      s_m = 4'b1010;
      @(negedge clk);
      if (i == 0) drive(4'h3, 1'b1);
      check_bit($sformatf("b2b_a bit%0d", i), s_l[i], s_m[i]);
    end
`ifdef SR_PISO_PARITY_EN
    @(negedge clk);
    check_bit("b2b_a parity", 1'b0, 1'b0);
`endif
    @(negedge clk);
    check_idle("b2b gap");
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] s_l;
      logic [3:0] s_m;
      s_l = 4'b0011;
      s_m = 4'b1100;
      @(negedge clk);
      check_bit($sformatf("b2b_b bit%0d", i), s_l[i], s_m[i]);
      if (i == 3) drive(4'h3, 1'b0);
    end
`ifdef SR_PISO_PARITY_EN
    @(negedge clk);
    drive(4'h3, 1'b0);
    check_bit("b2b_b parity", 1'b0, 1'b0);
`endif
    @(negedge clk);
    check_idle("b2b end");

    // Reset lands on E2 of a 0110 frame.
    @(negedge clk);
    drive(4'b0110, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'b0000, 1'b0);
    check_bit("abort bit0", 1'b0, 1'b0);
    @(negedge clk);
    check_bit("abort bit1", 1'b1, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort rst");
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle($sformatf("abort after%0d", i));
    end
    run_frame('{din: 4'h9, seq_l: 4'b1001, seq_m: 4'b1001, par: 1'b0}, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_piso_4bit_ctrl.md
SR_PISO_4BIT_CTRL -- requirements
Module: sr_piso_4bit_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per frame; legal range 2..16.
REQ-002 Parameter: MSB_FIRST, default 0; 0 = bit 0 shifted out first, 1 = bit WIDTH-1 first.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port din, input, WIDTH bits, parallel word to serialize.
REQ-006 The block SHALL have port din_valid, input, 1 bit, din holds a word to transfer.
REQ-007 The block SHALL have port din_ready, output, 1 bit, block can accept a word this cycle.
REQ-008 The block SHALL have port sout, output, 1 bit, serial data, feeds the downstream shift register's serial input.
REQ-009 The block SHALL have port sout_valid, output, 1 bit, sout carries a frame bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY is present only per REQ-028.
REQ-012 din_ready SHALL be combinational and equal to (state == IDLE); it is low in all other states.
REQ-013 A transfer SHALL occur on a rising edge where din_valid && din_ready; otherwise din is ignored.
REQ-014 At the accepting edge E0: shreg <= din; sout <= first bit per MSB_FIRST; sout_valid <= 1; bit counter <= 1; state <= SHIFT.
REQ-015 In SHIFT, at each edge while counter < WIDTH: sout <= next bit in order; counter increments by 1.
REQ-016 At edge E(WIDTH) with parity disabled: sout <= 0; sout_valid <= 0; counter <= 0; state <= IDLE.
REQ-017 Each data bit SHALL be held on sout for exactly one clock; latency from acceptance to first bit on sout is one edge (registered output).
REQ-018 sout SHALL be registered, with no combinational path from din to sout.
REQ-019 The captured word SHALL be unaffected by din or din_valid changes after E0.
REQ-020 din_valid held high continuously SHALL yield frames separated by exactly one idle cycle with sout = 0 and sout_valid = 0.
REQ-021 In IDLE, sout SHALL be 0, matching the downstream idle serial level.
REQ-022 busy SHALL be registered and equal to (state != IDLE).
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never exceed WIDTH.

Reset
REQ-024 When rst == 0 at a rising edge, state <= IDLE, shreg <= 0, counter <= 0, sout <= 0, sout_valid <= 0 and busy <= 0.
REQ-025 Reset SHALL take priority over any transfer in the same cycle; a word presented with din_valid during reset is dropped.
REQ-026 Reset asserted mid-frame SHALL abort the frame, with no further frame bits emitted after the reset edge.
REQ-027 din_ready SHALL be 1 in the first cycle after rst returns high.

Configuration
REQ-028 With macro SR_PISO_PARITY_EN defined: at edge E(WIDTH), state <= PARITY, sout <= even parity (XOR of all captured bits), sout_valid <= 1; at the next edge, sout <= 0, sout_valid <= 0, state <= IDLE; the frame is WIDTH+1 bits.
REQ-029 Without SR_PISO_PARITY_EN: the PARITY state and its logic SHALL be absent, and frames are WIDTH bits per REQ-016.

Verification
REQ-030 Hold rst = 0 for 2 edges with din_valid = 1 and din = 4'b1111, then release -> sout = 0, sout_valid = 0, busy = 0 throughout reset; din_ready = 1 after release; no frame emitted.
REQ-031 WIDTH = 4, MSB_FIRST = 0, din = 4'b1010, one-cycle valid pulse -> sout = 0,1,0,1 on cycles E0..E3 with sout_valid = 1; E4: sout_valid = 0; din_ready = 1 at E4.
REQ-032 MSB_FIRST = 1, din = 4'b1100 -> sout sequence 1,1,0,0.
REQ-033 din_valid held high with words 4'h5 then 4'h3 -> 1,0,1,0, one idle cycle, 1,1,0,0; din changes during shifting do not alter the current frame.
REQ-034 rst driven low at E2 of a din = 4'b0110 frame -> sout_valid = 0 and state = IDLE from that edge; the next accepted word 4'h9 serializes correctly.
REQ-035 SR_PISO_PARITY_EN defined, din = 4'b1011 -> sout sequence 1,1,0,1, then parity bit 1 with sout_valid = 1, then idle; din = 4'b0011 gives parity bit 0.
